// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the SRAM subordinate.
// Transfer/response encodings, size codes and slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        SLV_IDLE = 2'd0,
        SLV_WAIT = 2'd1,
        SLV_ERR1 = 2'd2,
        SLV_ERR2 = 2'd3
    } slv_state_e;

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised SRAM: byte-enable synchronous write,
// asynchronous read at the same word address.
module ahb_slv_mem #(
    parameter int   DATA_WIDTH = 32,
    parameter int   MEM_DEPTH  = 1024,
    localparam int  NB         = DATA_WIDTH / 8,
    localparam int  AW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic [NB-1:0]         be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB subordinate serving an internal SRAM with wait states,
// byte-lane writes and a two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTB,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic [1:0]              HRESP
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int AW   = $clog2(MEM_DEPTH);
    localparam int RW   = OFFW + AW;
    localparam int unsigned MEM_BYTES = MEM_DEPTH * NB;

    slv_state_e            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  dp_valid_q, dp_valid_d;
    logic [RW-1:0]         addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  accept;
    logic                  addr_err;
    logic [2:0]            align_mask;
    logic [NB-1:0]         lane_mask;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_ok;

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        unique case (HSIZE)
            HSIZE_BYTE: align_mask = 3'b000;
            HSIZE_HALF: align_mask = 3'b001;
            HSIZE_WORD: align_mask = 3'b011;
            default:    align_mask = 3'b111;
        endcase
    end

    assign addr_err = (HADDR >= ADDR_WIDTH'(MEM_BYTES))
                    | (HSIZE > 3'(OFFW))
                    | ((HADDR[2:0] & align_mask) != 3'b000);

    always_comb begin
        lane_mask = '1;
        if (size_q == HSIZE_BYTE) begin
            lane_mask = NB'(1) << addr_q[OFFW-1:0];
        end else if (size_q == HSIZE_HALF) begin
            lane_mask = NB'(3) << {addr_q[OFFW-1:1], 1'b0};
        end
    end

    // IDLE with dp_valid_q set is the completing cycle of an OKAY phase.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = 1'b0;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        be         = '0;
        unique case (state_q)
            SLV_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 3'd0) begin
                    state_d    = SLV_IDLE;
                    dp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            SLV_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = SLV_ERR2;
            end
            default: begin
                if (state_q == SLV_ERR2) begin
                    HRESP = HRESP_ERROR;
                end
                if (dp_valid_q && write_q) begin
                    be = lane_mask & HWSTB;
                end
                state_d = SLV_IDLE;
                if (accept) begin
                    addr_d  = HADDR[RW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (addr_err) begin
                        state_d = SLV_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = SLV_WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end else begin
                        dp_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= SLV_IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
        end
    end

    ahb_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (HCLK),
        .be    (be),
        .addr  (addr_q[RW-1:OFFW]),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HRDATA = (dp_valid_q && !write_q) ? mem_rdata : '0;

    assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: two slaves (0 and 2 wait states) driven by a pipelined
// manager, checked every cycle against a byte-level memory model.
module tb_ahb_sram_slave;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        int          gap;
        logic        lit_en;
        logic [31:0] lit;
        int          rst_c;
    } txn_t;

    localparam int MAXT = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [3:0]  hprot     [2];
    logic        hmastlock [2];
    logic [31:0] hwdata    [2];
    logic [3:0]  hwstb     [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic [31:0] hrdata    [2];
    logic [1:0]  hresp     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_sram_slave #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_DEPTH   (1024),
            .WAIT_STATES (2 * g)
        ) u_dut (
            .HCLK      (clk),
            .HRESETn   (rst_n[g]),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HTRANS    (htrans[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (hburst[g]),
            .HPROT     (hprot[g]),
            .HMASTLOCK (hmastlock[g]),
            .HWDATA    (hwdata[g]),
            .HWSTB     (hwstb[g]),
            .HREADY    (hready[g]),
            .HREADYOUT (hreadyout[g]),
            .HRDATA    (hrdata[g]),
            .HRESP     (hresp[g])
        );
    end

    txn_t       tx [2][MAXT];
    int         n_tx [2], nxt [2], ap_i [2], dp_i [2];
    int         dp_c [2], gap_left [2], rst_cnt [2];
    logic       ap_valid [2], dp_on [2];
    logic [7:0] mm [2][64];
    int         n_vec, n_bad;

    function automatic int ws(int d);
        return 2 * d;
    endfunction

    function automatic logic is_err(txn_t t);
        longint a = longint'(t.addr);
        longint s = longint'(1) << t.size;
        return (a >= 1024 * 4) || (t.size > 3'd2) || ((a % s) != 0);
    endfunction

    function automatic logic [3:0] lanes(txn_t t);
        int o = int'(t.addr % 4);
        logic [3:0] m;
        if (t.size == 3'd0) m = 4'(1 << o);
        else if (t.size == 3'd1) m = 4'(3 << o);
        else m = 4'hF;
        return m & t.wstb;
    endfunction

    function automatic logic [31:0] mword(int d, logic [31:0] a);
        int b = int'(a % 64) / 4 * 4;
        return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
    endfunction

    function automatic logic exp_rdy(int d);
        if (!dp_on[d]) return 1'b1;
        if (is_err(tx[d][dp_i[d]])) return dp_c[d] == 1;
        return dp_c[d] == ws(d);
    endfunction

    function automatic logic [1:0] exp_resp(int d);
        if (dp_on[d] && is_err(tx[d][dp_i[d]])) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_data(int d);
        txn_t t;
        if (!dp_on[d]) return 32'd0;
        t = tx[d][dp_i[d]];
        if (is_err(t) || t.wr || dp_c[d] != ws(d)) return 32'd0;
        return mword(d, t.addr);
    endfunction

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %h, expected %h",
                     nm, d, $time, act, exp);
        end
    endtask

    task automatic add(int d, logic wr, logic [31:0] a, logic [2:0] s,
                       logic [31:0] wd, logic [3:0] st, int gap,
                       logic le, logic [31:0] lv, int rc);
        if (n_tx[d] < MAXT) begin
            tx[d][n_tx[d]] = '{wr, a, s, wd, st, gap, le, lv, rc};
            n_tx[d]++;
        end
    endtask

    task automatic build(int d);
        logic [31:0] a;
        logic [2:0]  s;
        int          r;
        for (int w = 0; w < 16; w++)
            add(d, 1, 32'(w * 4), 2, $urandom, 4'hF, 0, 0, 0, -1);
        add(d, 1, 32'h10, 2, 32'hDEADBEEF, 4'hF, 0, 0, 0, -1);
        add(d, 0, 32'h10, 2, 0, 0, 0, 1, 32'hDEADBEEF, -1);
        add(d, 1, 32'h10, 2, 32'h11223344, 4'hF, 1, 0, 0, -1);
        add(d, 1, 32'h13, 0, 32'hAB000000, 4'hF, 0, 0, 0, -1);
        add(d, 0, 32'h10, 2, 0, 0, 0, 1, 32'hAB223344, -1);
        add(d, 1, 32'h20, 2, 32'h0, 4'hF, 0, 0, 0, -1);
        add(d, 1, 32'h20, 2, 32'hFFFFFFFF, 4'h5, 0, 0, 0, -1);
        add(d, 0, 32'h20, 2, 0, 0, 0, 1, 32'h00FF00FF, -1);
        add(d, 0, 32'h1000, 2, 0, 0, 0, 0, 0, -1);
        add(d, 0, 32'h01, 1, 0, 0, 0, 0, 0, -1);
        add(d, 1, 32'h1020, 2, 32'hFFFFFFFF, 4'hF, 0, 0, 0, -1);
        add(d, 1, 32'h21, 1, 32'hFFFFFFFF, 4'hF, 1, 0, 0, -1);
        add(d, 1, 32'h22, 2, 32'hFFFFFFFF, 4'hF, 0, 0, 0, -1);
        add(d, 1, 32'h20, 3, 32'hFFFFFFFF, 4'hF, 0, 0, 0, -1);
        add(d, 0, 32'h20, 2, 0, 0, 0, 1, 32'h00FF00FF, -1);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 15);
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 63)) & ~((32'd1 << s) - 32'd1);
            if (r == 0) a = $urandom | 32'h0000_1000;
            else if (r == 1) s = 3'd3;
            else if (r == 2) begin
                s = 3'($urandom_range(1, 2));
                a = a | 32'd1;
            end
            add(d, 1'($urandom_range(0, 1)), a, s, $urandom,
                4'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                0, 0, -1);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            chk("hreadyout", d, 32'(hreadyout[d]), 32'(exp_rdy(d)));
            chk("hresp", d, 32'(hresp[d]), 32'(exp_resp(d)));
            chk("hrdata", d, hrdata[d], exp_data(d));
            if (dp_on[d] && exp_rdy(d) && tx[d][dp_i[d]].lit_en)
                chk("lit_rdata", d, hrdata[d], tx[d][dp_i[d]].lit);
        end
    endtask

    task automatic on_edge();
        logic       done;
        txn_t       t;
        logic [3:0] m;
        int         b;
        for (int d = 0; d < 2; d++) begin
            done = dp_on[d] && exp_rdy(d);
            if (done) begin
                t = tx[d][dp_i[d]];
                if (t.wr && !is_err(t)) begin
                    m = lanes(t);
                    b = int'(t.addr % 64) / 4 * 4;
                    for (int k = 0; k < 4; k++)
                        if (m[k]) mm[d][b+k] = t.wdata[8*k +: 8];
                end
            end
            if (hsel[d] && hready[d] && htrans[d][1]) begin
                dp_on[d]    = 1'b1;
                dp_i[d]     = ap_i[d];
                dp_c[d]     = 0;
                ap_valid[d] = 1'b0;
            end else if (done) begin
                dp_on[d] = 1'b0;
            end else if (dp_on[d]) begin
                dp_c[d]++;
            end
        end
    endtask

    task automatic drive();
        txn_t t;
        for (int d = 0; d < 2; d++) begin
            if (rst_cnt[d] > 0) begin
                rst_cnt[d]--;
                if (rst_cnt[d] == 0) rst_n[d] = 1'b1;
            end
            if (dp_on[d] && tx[d][dp_i[d]].rst_c == dp_c[d]) begin
                rst_n[d]   = 1'b0;
                dp_on[d]   = 1'b0;
                rst_cnt[d] = 2;
            end
            hburst[d]    = 3'($urandom);
            hprot[d]     = 4'($urandom);
            hmastlock[d] = 1'($urandom);
            hwdata[d]    = $urandom;
            hwstb[d]     = 4'($urandom);
            if (dp_on[d] && tx[d][dp_i[d]].wr) begin
                hwdata[d] = tx[d][dp_i[d]].wdata;
                hwstb[d]  = tx[d][dp_i[d]].wstb;
            end
            if (!ap_valid[d] && nxt[d] < n_tx[d] && rst_n[d]) begin
                if (gap_left[d] > 0) begin
                    gap_left[d]--;
                end else begin
                    ap_valid[d] = 1'b1;
                    ap_i[d]     = nxt[d];
                    nxt[d]++;
                    gap_left[d] = (nxt[d] < n_tx[d]) ? tx[d][nxt[d]].gap : 0;
                end
            end
            if (!rst_n[d]) begin
                hsel[d]   = 1'b0;
                htrans[d] = 2'b00;
                hready[d] = 1'b1;
            end else if (ap_valid[d]) begin
                t         = tx[d][ap_i[d]];
                hsel[d]   = 1'b1;
                htrans[d] = {1'b1, 1'($urandom)};
                haddr[d]  = t.addr;
                hwrite[d] = t.wr;
                hsize[d]  = t.size;
                hready[d] = dp_on[d] ? exp_rdy(d)
                                     : ($urandom_range(0, 7) != 0);
            end else begin
                hsel[d]   = 1'($urandom);
                htrans[d] = hsel[d] ? {1'b0, 1'($urandom)} : 2'($urandom);
                haddr[d]  = $urandom;
                hwrite[d] = 1'($urandom);
                hsize[d]  = 3'($urandom);
                hready[d] = dp_on[d] ? exp_rdy(d)
                                     : ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    function automatic logic drained();
        for (int d = 0; d < 2; d++)
            if (nxt[d] < n_tx[d] || ap_valid[d] || dp_on[d] || rst_cnt[d] != 0)
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic run(int budget);
        int cyc = 0;
        while (!drained() && cyc < budget) begin
            drive();
            @(negedge clk);
            compare();
            @(posedge clk);
            on_edge();
            #1;
            cyc++;
        end
        if (!drained()) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got busy after %0d cycles, expected idle",
                     budget);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d]     = 1'b0;
            hsel[d]      = 1'b0;
            haddr[d]     = '0;
            htrans[d]    = 2'b00;
            hwrite[d]    = 1'b0;
            hsize[d]     = 3'd0;
            hburst[d]    = 3'd0;
            hprot[d]     = 4'd0;
            hmastlock[d] = 1'b0;
            hwdata[d]    = '0;
            hwstb[d]     = '0;
            hready[d]    = 1'b1;
            n_tx[d]      = 0;
            nxt[d]       = 0;
            ap_i[d]      = 0;
            dp_i[d]      = 0;
            dp_c[d]      = 0;
            gap_left[d]  = 0;
            rst_cnt[d]   = 0;
            ap_valid[d]  = 1'b0;
            dp_on[d]     = 1'b0;
            build(d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_hreadyout", d, 32'(hreadyout[d]), 32'd1);
            chk("reset_hresp", d, 32'(hresp[d]), 32'd0);
            chk("reset_hrdata", d, hrdata[d], 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        run(6000);

        add(1, 1, 32'h30, 2, 32'h5A5A1234, 4'hF, 0, 0, 0, -1);
        add(1, 1, 32'h30, 2, 32'hCAFEF00D, 4'hF, 0, 0, 0, 1);
        add(1, 0, 32'h30, 2, 0, 0, 0, 1, 32'h5A5A1234, -1);
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB subordinate that responds to a manager's transfers by serving reads and writes from an internal word-organised SRAM. Configurable wait states, byte-lane writes, and a two-cycle ERROR response for illegal accesses. Connects behind the AHB decoder/mux on the slave side of the bus, opposite the manager that drives the shared AHB interface.

## Interface
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: HWDATA/HRDATA width; legal values are 32 and 64.
- MEM_DEPTH, 1024: memory depth in DATA_WIDTH words.
- WAIT_STATES, 0: wait cycles inserted per OKAY transfer; range 0..7.

Ports:
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of the number of bytes.
- HBURST  in  3  burst type; ignored because every beat carries its own address.
- HPROT  in  4  protection; ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  DATA_WIDTH  write data for the data phase.
- HWSTB  in  DATA_WIDTH/8  per-byte write strobe for the data phase.
- HREADY  in  1  bus-wide ready, returned by the mux.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  DATA_WIDTH  read data.
- HRESP  out  2  response: OKAY=00, ERROR=01.

## Operation
- **Address-phase accept.** A transfer is accepted on an edge where HSEL & HREADY & HTRANS[1] are all high. At that edge, register addr, write, size and an error flag.
- **Error conditions.** The error flag is set when any of these holds:
  - byte address ≥ MEM_DEPTH·DATA_WIDTH/8;
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR is not aligned to HSIZE.
- **IDLE/BUSY or HSEL low.** The transfer is not accepted. The response is zero-wait OKAY.
- **FSM states.** The FSM has four states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: no active data phase, or the final cycle of an OKAY data phase.
    - On an accept with the error flag set, go to ERR1.
    - On an accept with WAIT_STATES > 0, go to WAIT and load the counter with WAIT_STATES−1.
    - On an accept with WAIT_STATES = 0, stay in IDLE; the data phase completes in one cycle.
  - WAIT: HREADYOUT=0. Decrement the counter each cycle. When the counter is 0, go to DONE, which is IDLE with a data phase pending.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Accepting a new address phase here is legal.
  - Encode IDLE with a `dp_valid` bit that marks a pending OKAY data-phase completion.
- **Lane mask.** The lane mask is the size/address lane mask AND HWSTB. Byte: 1 lane at addr[log2(DATA_WIDTH/8)−1:0]. Halfword: 2 lanes. Word/dword: all lanes.
- **Write commit.** A write commits the masked HWDATA bytes at the edge where the data phase completes (HREADYOUT=1, OKAY). An ERROR transfer never writes.
- **Read data.** Read asynchronously from the array at the registered word address. HRDATA is valid while HREADYOUT=1 in an OKAY read data phase and is 0 otherwise.
- **Back-to-back write then read of the same word.** The read returns the newly written data; no stall is inserted.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, counter=0, dp_valid=0. Memory contents are not reset.
- **Reset mid-transfer:** the transfer is aborted and a pending write is not committed. The slave is ready on the first edge after deassertion.
- **Latency:** an OKAY data phase lasts 1+WAIT_STATES cycles. An ERROR data phase lasts exactly 2 cycles and is never extended by WAIT_STATES.
- **Pipelining:** an address phase that overlaps the final data-phase cycle is accepted at the same edge.
- **HREADY low:** while HREADY=0 because another slave is stretching, nothing is sampled and no state advances except completion of this slave's own data phase.

## Structure
- **ahb_pkg** holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hresp_e (OKAY/ERROR);
  - the HSIZE constants BYTE=0, HALF=1, WORD=2, DWORD=3;
  - the slave FSM state enum.
- **ahb_slv_mem** is a sub-module: a MEM_DEPTH×DATA_WIDTH array with a byte-enable synchronous write and an asynchronous read.
- **ahb_sram_slave** holds the address-phase registers, the FSM, the wait counter and the error checks.

## Test plan
- WAIT_STATES=0. Write word 0xDEADBEEF to 0x10 (HWSTB=0xF), then read 0x10 back-to-back → HREADYOUT stays 1; HRDATA=0xDEADBEEF in the read data phase; HRESP=OKAY.
- WAIT_STATES=2. Read 0x10 → HREADYOUT=0 for 2 cycles, then 1 with data.
- Byte write 0xAB to 0x13 over word 0x11223344 with HWSTB=0xF → reading 0x10 returns 0xAB223344.
- Word write 0xFFFFFFFF to 0x20 with HWSTB=0x5 over 0 → reads 0x00FF00FF.
- Read at 0x1000 with MEM_DEPTH=1024 → cycle 1: HREADYOUT=0, HRESP=01; cycle 2: HREADYOUT=1, HRESP=01. A halfword at 0x01 gives the same response, and memory is unchanged.
- HRESETn low during the second wait cycle of a write to 0x30 → after reset HREADYOUT=1, HRESP=OKAY, and a read of 0x30 returns its pre-write value.
